// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
// Holds the state encodings and the occupancy decode.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ST_EMPTY: occ_of = 2'd0;
      ST_BUSY:  occ_of = 2'd1;
      ST_FULL:  occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_dfflr.sv
// General load-enable flop with synchronous active-low clear.
// Used for both the main and skid payload registers.
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (!rst)
      qout <= '0;
    else if (lden)
      qout <= dnxt;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: registered valid/ready on both sides.
// Main drives the output; skid absorbs one beat of backpressure.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    occ
);

  state_e        state;
  state_e        state_nxt;
  logic          in_hs;
  logic          out_hs;
  logic          main_ld;
  logic          skid_ld;
  logic [DW-1:0] main_d;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_hs)
            state_nxt = ST_BUSY;
        end
        ST_BUSY: begin
          if (in_hs && !out_hs)
            state_nxt = ST_FULL;
          else if (!in_hs && out_hs)
            state_nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (o_ready)
            state_nxt = ST_BUSY;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags only read registered state, never o_ready -> i_ready.
  always_comb begin
    o_valid = (state != ST_EMPTY);
    i_ready = (state != ST_FULL);
    occ     = occ_of(state);
    in_hs   = i_valid & i_ready;
    out_hs  = o_valid & o_ready;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = i_data;
    if (!flush) begin
      case (state)
        ST_EMPTY: main_ld = in_hs;
        ST_BUSY: begin
          main_ld = in_hs & out_hs;
          skid_ld = in_hs & ~o_ready;
        end
        ST_FULL: begin
          main_ld = o_ready;
          main_d  = skid_q;
        end
        default: main_ld = 1'b0;
      endcase
    end
  end

  sirv_gnrl_dfflr #(.DW(DW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .lden (main_ld),
    .dnxt (main_d),
    .qout (main_q)
  );

  sirv_gnrl_dfflr #(.DW(DW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .lden (skid_ld),
    .dnxt (i_data),
    .qout (skid_q)
  );

  assign o_data = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table plus
// randomized traffic against a queue-based reference.
module tb_pipe_skid_stage;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    occ;

  int total;
  int bad;

  typedef struct {
    logic          r;
    logic          f;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          eov;
    logic          eir;
    logic [1:0]    eocc;
    logic [DW-1:0] ed;
    logic          cd;
  } vec_t;

  vec_t vq[$];
  logic [DW-1:0] mq[$];

  pipe_skid_stage #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .occ     (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv,
                     input logic [DW-1:0] d, input logic ordy,
                     input logic eov, input logic eir,
                     input logic [1:0] eocc, input logic [DW-1:0] ed,
                     input logic cd);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.eocc = eocc; v.ed = ed; v.cd = cd;
    vq.push_back(v);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    flush = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    o_ready = 1'b0;

    // reset with valid input held high
    add(0,0,1,32'h55,1, 0,1,0,32'h0,1);
    add(0,0,1,32'h55,1, 0,1,0,32'h0,1);
    add(1,0,1,32'h11,0, 1,1,1,32'h11,1);
    add(1,0,0,32'h0,1,  0,1,0,32'h0,0);
    // streaming at one beat per cycle
    for (int k = 1; k <= 8; k++)
      add(1,0,1,DW'(k),1, 1,1,1,DW'(k),1);
    add(1,0,0,32'h0,1,  0,1,0,32'h0,0);
    // backpressure into FULL, then drain
    add(1,0,1,32'hA,0,  1,1,1,32'hA,1);
    add(1,0,1,32'hB,0,  1,0,2,32'hA,1);
    add(1,0,0,32'h0,0,  1,0,2,32'hA,1);
    add(1,0,0,32'h0,1,  1,1,1,32'hB,1);
    add(1,0,0,32'h0,1,  0,1,0,32'h0,0);
    // flush while FULL
    add(1,0,1,32'hC,0,  1,1,1,32'hC,1);
    add(1,0,1,32'hD,0,  1,0,2,32'hC,1);
    add(1,1,1,32'hE,0,  0,1,0,32'h0,0);
    add(1,0,0,32'h0,1,  0,1,0,32'h0,0);
    // flush discards a same-cycle input handshake
    add(1,0,1,32'h21,0, 1,1,1,32'h21,1);
    add(1,1,1,32'h22,1, 0,1,0,32'h0,0);
    add(1,0,0,32'h0,1,  0,1,0,32'h0,0);
    // reset mid-operation from FULL, over a flush
    add(1,0,1,32'h31,0, 1,1,1,32'h31,1);
    add(1,0,1,32'h32,0, 1,0,2,32'h31,1);
    add(0,1,1,32'h33,1, 0,1,0,32'h0,1);
    add(1,0,0,32'h0,1,  0,1,0,32'h0,1);

    for (int i = 0; i < vq.size(); i++) begin
      rst     = vq[i].r;
      flush   = vq[i].f;
      i_valid = vq[i].iv;
      i_data  = vq[i].d;
      o_ready = vq[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ov", i), DW'(o_valid), DW'(vq[i].eov));
      chk($sformatf("vec%0d ir", i), DW'(i_ready), DW'(vq[i].eir));
      chk($sformatf("vec%0d occ", i), DW'(occ), DW'(vq[i].eocc));
      if (vq[i].cd)
        chk($sformatf("vec%0d data", i), o_data, vq[i].ed);
    end

    // i_ready must not react to o_ready within a cycle
    rst = 1; flush = 0; i_valid = 1; o_ready = 0; i_data = 32'h41;
    @(posedge clk); #1;
    i_data = 32'h42;
    @(posedge clk); #1;
    i_valid = 0;
    o_ready = 1;
    #1;
    chk("comb ir", DW'(i_ready), DW'(0));
    chk("comb ov", DW'(o_valid), DW'(1));
    @(posedge clk); #1;
    o_ready = 1;
    @(posedge clk); #1;
    chk("drain occ", DW'(occ), DW'(0));

    // randomized traffic; model is an ordered queue of capacity 2
    mq.delete();
    for (int c = 0; c < 10000; c++) begin
      logic r, f, iv, ordy, ihs, ohs;
      logic [DW-1:0] d;
      r    = ($urandom_range(0, 199) != 0);
      f    = ($urandom_range(0, 31) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = $urandom_range(0, 1) == 1;
      d    = $urandom;
      rst = r; flush = f; i_valid = iv; o_ready = ordy; i_data = d;
      ihs = iv && (mq.size() < 2);
      ohs = ordy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (!r || f) begin
        mq.delete();
      end else begin
        if (ohs) void'(mq.pop_front());
        if (ihs) mq.push_back(d);
      end
      chk($sformatf("rnd%0d occ", c), DW'(occ), DW'(mq.size()));
      chk($sformatf("rnd%0d ov", c), DW'(o_valid), DW'(mq.size() > 0));
      chk($sformatf("rnd%0d ir", c), DW'(i_ready), DW'(mq.size() < 2));
      if (mq.size() > 0)
        chk($sformatf("rnd%0d data", c), o_data, mq[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
